// File: rtl/router_ingress.sv
// Ingress controller of the 1x3 router: parses packets, applies source back-pressure and steers
// each packet into one of three FIFOs. Define ROUTER_INGRESS_PARITY_CHECK_EN to enable the parity check and err.
module router_ingress (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] soft_reset,
    output logic [7:0] dout,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE, DROP, WAIT_EMPTY, LFD, HDR, DATA, PARITY, CHECK
    } state_t;

    state_t      state, next_state;
    logic [7:0]  hdr_reg;
    logic [1:0]  addr_reg;
    logic [5:0]  cnt;
    logic        wr;
    logic        abort;
`ifdef ROUTER_INGRESS_PARITY_CHECK_EN
    logic [7:0]  acc;
    logic [7:0]  rx_parity;
`endif

    always_comb begin
        next_state = state;
        dout       = '0;
        lfd_state  = 1'b0;
        busy       = 1'b0;
        wr         = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: if (pkt_valid) begin
                if (data_in[1:0] == 2'd3)
                    next_state = DROP;
                else if (fifo_empty[data_in[1:0]])
                    next_state = LFD;
                else
                    next_state = WAIT_EMPTY;
            end
            DROP: if (pkt_valid && cnt == '0) next_state = IDLE;
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (fifo_empty[addr_reg]) next_state = LFD;
            end
            LFD: begin
                busy       = 1'b1;
                lfd_state  = 1'b1;
                next_state = HDR;
            end
            HDR: begin
                busy       = 1'b1;
                dout       = hdr_reg;
                wr         = 1'b1;
                next_state = (hdr_reg[7:2] != '0) ? DATA : PARITY;
            end
            DATA: begin
                busy = fifo_full[addr_reg];
                dout = data_in;
                wr   = pkt_valid & ~fifo_full[addr_reg];
                if (wr && cnt == 6'd1) next_state = PARITY;
            end
            PARITY: begin
                busy = fifo_full[addr_reg];
                dout = data_in;
                wr   = pkt_valid & ~fifo_full[addr_reg];
`ifdef ROUTER_INGRESS_PARITY_CHECK_EN
                if (wr) next_state = CHECK;
`else
                if (wr) next_state = IDLE;
`endif
            end
`ifdef ROUTER_INGRESS_PARITY_CHECK_EN
            CHECK: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
        // Soft reset of the active FIFO aborts the packet and suppresses this cycle's write
        if (state != IDLE && state != DROP && soft_reset[addr_reg]) begin
            abort      = 1'b1;
            wr         = 1'b0;
            next_state = IDLE;
        end
    end

    assign write_enb = wr ? (3'b001 << addr_reg) : 3'b000;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            hdr_reg  <= '0;
            addr_reg <= '0;
            cnt      <= '0;
`ifdef ROUTER_INGRESS_PARITY_CHECK_EN
            acc       <= '0;
            rx_parity <= '0;
            err       <= 1'b0;
`endif
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (pkt_valid) begin
                    cnt <= data_in[7:2];
                    if (data_in[1:0] != 2'd3) begin
                        hdr_reg  <= data_in;
                        addr_reg <= data_in[1:0];
`ifdef ROUTER_INGRESS_PARITY_CHECK_EN
                        acc <= data_in;
                        err <= 1'b0;
`endif
                    end
                end
                DROP: if (pkt_valid && cnt != '0) cnt <= cnt - 6'd1;
                DATA: if (wr) begin
                    cnt <= cnt - 6'd1;
`ifdef ROUTER_INGRESS_PARITY_CHECK_EN
                    acc <= acc ^ data_in;
`endif
                end
`ifdef ROUTER_INGRESS_PARITY_CHECK_EN
                PARITY: if (wr) rx_parity <= data_in;
                CHECK:  if (!abort) err <= (acc != rx_parity);
`endif
                default: ;
            endcase
        end
    end

`ifndef ROUTER_INGRESS_PARITY_CHECK_EN
    assign err = 1'b0;
`endif

endmodule
